// File: rtl/rot_seq_ctrl.sv
// Multi-cycle rotate sequencer: one single-bit rotate per clock until the
// requested amount is used up, then hold the result until it is consumed.
module rot_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [SHW-1:0]   amount,
  input  logic             dir,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] CNT_ZERO = '0;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_count;
  logic             r_dir;

  logic [WIDTH-1:0] w_step;
  logic             w_accept;
  logic             w_lastStep;

  // dir=0 moves bit i-1 into bit i (wrapping MSB to LSB); dir=1 is the reverse.
  always_comb begin
    w_step = r_data;
    if (r_dir) begin
      w_step = {r_data[0], r_data[WIDTH-1:1]};
    end else begin
      w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
    end
  end

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_lastStep = (r_count == CNT_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= a_in;
            r_count <= amount;
            r_dir   <= dir;
            r_state <= (amount == CNT_ZERO) ? S_DONE : S_ROT;
          end
        end
        S_ROT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else begin
            r_data  <= w_step;
            r_count <= r_count - CNT_ONE;
            if (w_lastStep) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Abort takes priority over a concurrent consumer handshake.
          if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_ROT);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_data;

endmodule

// File: tb/tb_rot_seq_ctrl.sv
// Self-checking bench for rot_seq_ctrl: directed cases plus a randomized
// regression compared against an arithmetic rotate model.
module tb_rot_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [4:0]  amount;
  logic        dir;
  logic        abort;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int          checkCount;
  int          passCount;
  logic [31:0] lastResult;

  rot_seq_ctrl #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .amount    (amount),
    .dir       (dir),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dir=0 is a numeric rotate toward the MSB, dir=1 toward the LSB.
  function automatic logic [31:0] refRotate(input logic [31:0] a, input int k, input logic d);
    if (k == 0) return a;
    if (!d) return (a << k) | (a >> (32 - k));
    return (a >> k) | (a << (32 - k));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete operation, starting and ending at a falling edge with the DUT idle.
  // abortAt selects the cycle (counted from the accept) at which abort or reset hits.
  task automatic applyStimulus(input logic [31:0] a, input int amt, input logic d,
                               input int stall, input int abortAt, input bit useReset);
    logic [31:0] expected;
    int          n;
    bit          done;
    expected = refRotate(a, amt, d);
    checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a_in      = a;
    amount    = amt[4:0];
    dir       = d;
    out_ready = 1'b0;
    abort     = ($urandom_range(0, 7) == 0);
    nextCycle();
    in_valid = $urandom_range(0, 1);
    a_in     = $urandom;
    amount   = 5'($urandom);
    dir      = 1'($urandom);
    abort    = 1'b0;
    n        = 1;
    done     = 0;
    while (!done) begin
      if (abortAt == n) begin
        out_ready = 1'($urandom);
        if (useReset) rst_n = 1'b0;
        else abort = 1'b1;
        nextCycle();
        rst_n     = 1'b1;
        abort     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("abort_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        if (useReset) checkOutput("reset_result", result, 32'd0);
        done = 1;
      end else begin
        checkOutput("busy", {31'b0, busy}, {31'b0, (n <= amt)});
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, (n > amt)});
        checkOutput("in_ready_op", {31'b0, in_ready}, 32'd0);
        if (n > amt) begin
          checkOutput("result", result, expected);
          lastResult = result;
          out_ready  = (n - amt - 1 >= stall);
          if (out_ready) begin
            nextCycle();
            out_ready = 1'b0;
            in_valid  = 1'b0;
            checkOutput("ret_in_ready", {31'b0, in_ready}, 32'd1);
            checkOutput("ret_out_valid", {31'b0, out_valid}, 32'd0);
            done = 1;
          end else begin
            nextCycle();
          end
        end else begin
          nextCycle();
        end
        n++;
      end
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    lastResult = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    a_in       = 32'hDEADBEEF;
    amount     = 5'd3;
    dir        = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b0;

    @(negedge clk);
    nextCycle();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    nextCycle();
    checkOutput("post_rst_idle", {31'b0, in_ready}, 32'd1);
    checkOutput("post_rst_result", result, 32'd0);

    applyStimulus(32'h00000001, 1, 1'b0, 0, 0, 0);
    checkOutput("dir0_amt1", lastResult, 32'h00000002);
    applyStimulus(32'h00000001, 1, 1'b1, 0, 0, 0);
    checkOutput("dir1_amt1", lastResult, 32'h80000000);
    applyStimulus(32'h80000001, 0, 1'b0, 0, 0, 0);
    checkOutput("amt0", lastResult, 32'h80000001);
    applyStimulus(32'h12345678, 31, 1'b0, 5, 0, 0);
    checkOutput("amt31", lastResult, 32'h091A2B3C);
    checkOutput("amt31_equiv", lastResult, refRotate(32'h12345678, 1, 1'b1));

    lastResult = '0;
    applyStimulus(32'hF0000000, 8, 1'b0, 0, 3, 0);
    checkOutput("no_result_after_abort", lastResult, 32'd0);
    applyStimulus(32'h0000000F, 4, 1'b1, 0, 0, 0);
    checkOutput("after_abort", lastResult, 32'hF0000000);
    applyStimulus(32'hF0000000, 8, 1'b0, 0, 3, 1);
    applyStimulus(32'h0000000F, 4, 1'b1, 0, 0, 0);
    checkOutput("after_reset", lastResult, 32'hF0000000);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      int          ramt;
      int          rstall;
      int          rabort;
      ra     = $urandom;
      ramt   = $urandom_range(0, 31);
      rstall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      rabort = 0;
      if ($urandom_range(0, 19) == 0) rabort = $urandom_range(1, ramt + 1 + rstall);
      applyStimulus(ra, ramt, 1'($urandom), rstall, rabort, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
